// File: rtl/lsu_port.sv
// lsu_port: RV32I load/store unit port between a core request channel and a single-port RAM.
// Latency: accept->rsp_valid is 2 cycles for stores, 2+READ_WAIT for loads, 1 for faults.
// Backpressure: req_ready only in IDLE (one request in flight); response is a pulse, never stalled.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (accepted on a rising edge with both high)
//   req_we, req_funct3       store/load select and RV32I width code
//   req_addr, req_wdata      byte address and right-aligned store data
//   rsp_valid/rsp_fault      one-cycle response pulse; fault flags misaligned/illegal requests
//   rsp_rdata                extended load data, 0 for stores and faults
//   mem_addr/mem_r/mem_w     registered word address, read enable, byte-lane write strobes
//   mem_in / mem_out         lane-shifted store data out, combinational RAM read data in
module lsu_port #(
  parameter int READ_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_r,
  output logic [3:0]  mem_w,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out
);

  localparam logic [3:0] LP_WAIT = 4'(READ_WAIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Captured request fields that are still needed after the accept edge.
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;

  // Registered RAM-side outputs.
  logic [31:0] r_mem_addr;
  logic        r_mem_r;
  logic [3:0]  r_mem_w;
  logic [31:0] r_mem_in;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_fault;
  logic        w_access_done;
  logic [3:0]  w_lane_mask;
  logic [31:0] w_lane_data;
  logic [31:0] w_lane_bytes;
  logic [31:0] w_shift;
  logic [31:0] w_load_ext;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // Request legality: unsigned widths only exist for loads, and H/W must be naturally aligned.
  always_comb begin
    w_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = req_we;
      default:                w_illegal = 1'b1;
    endcase
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  assign w_fault = w_illegal | w_misalign;

  // Store lane selection; data is replicated then masked so unused lanes carry zero.
  always_comb begin
    w_lane_mask = 4'b1111;
    w_lane_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_lane_mask = 4'b0001 << req_addr[1:0];
        w_lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_lane_bytes = {{8{w_lane_mask[3]}}, {8{w_lane_mask[2]}},
                         {8{w_lane_mask[1]}}, {8{w_lane_mask[0]}}};

  // Stores always take a single ACCESS cycle; loads wait until the down-counter hits zero.
  assign w_access_done = (r_state == S_ACCESS) && (r_we || (r_cnt == 4'd0));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_fault ? S_FAULT : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_access_done) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      S_FAULT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      r_cnt      <= 4'd0;
      r_rdata    <= 32'h0;
      r_mem_addr <= 32'h0;
      r_mem_r    <= 1'b0;
      r_mem_w    <= 4'b0000;
      r_mem_in   <= 32'h0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_off    <= req_addr[1:0];
        r_cnt    <= LP_WAIT;
      end else if ((r_state == S_ACCESS) && !w_access_done) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // RAM controls are loaded on the accept edge so they are live for the whole
      // ACCESS window, and cleared on the last ACCESS edge; a fault never drives them.
      if (w_accept && !w_fault) begin
        r_mem_addr <= {req_addr[31:2], 2'b00};
        r_mem_r    <= ~req_we;
        r_mem_w    <= req_we ? w_lane_mask : 4'b0000;
        r_mem_in   <= req_we ? (w_lane_data & w_lane_bytes) : 32'h0;
      end else if (w_access_done) begin
        r_mem_addr <= 32'h0;
        r_mem_r    <= 1'b0;
        r_mem_w    <= 4'b0000;
        r_mem_in   <= 32'h0;
      end

      if (w_access_done && !r_we) begin
        r_rdata <= mem_out;
      end
    end
  end

  // Load extraction: bring the addressed byte/halfword down to bit 0, then extend.
  assign w_shift = r_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_ext = r_rdata;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load_ext = {24'h0, w_shift[7:0]};
      3'b101:  w_load_ext = {16'h0, w_shift[15:0]};
      default: w_load_ext = r_rdata;
    endcase
  end

  // ---------------- FSM: output logic ----------------
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_fault = 1'b0;
    rsp_rdata = 32'h0;
    case (r_state)
      S_IDLE:  req_ready = 1'b1;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_we ? 32'h0 : w_load_ext;
      end
      S_FAULT: begin
        rsp_valid = 1'b1;
        rsp_fault = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr = r_mem_addr;
  assign mem_r    = r_mem_r;
  assign mem_w    = r_mem_w;
  assign mem_in   = r_mem_in;

endmodule
